// File: rtl/io_input_ctrl_pkg.sv
// Shared definitions for the operator-input controller: FSM encoding and the
// ecall service code the core decodes to form read_req.
package io_input_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned DATA_W  = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_RELEASE = 2'd1,
    ST_WAIT_PRESS   = 2'd2,
    ST_DONE         = 2'd3
  } state_e;

  // a7 value of the "read integer from operator" ecall
  localparam logic [DATA_W-1:0] ECALL_READ_INPUT = 32'd5;

endpackage

// File: rtl/io_input_ctrl_btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one active-high button;
// emits the clean level and a one-cycle pulse per accepted press.
module io_input_ctrl_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic btn_stable,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             sync_btn;
  logic             btn_prev;
  logic [CNT_W-1:0] cnt;

  assign sync_btn = sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], button_in};
    end
  end

  // Level is accepted after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else if (sync_btn == btn_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt        <= '0;
      btn_stable <= ~btn_stable;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_prev    <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      btn_prev    <= btn_stable;
      press_pulse <= btn_stable & ~btn_prev;
    end
  end

endmodule

// File: rtl/io_input_ctrl.sv
// Input-ecall service: stalls fetch until the operator presses continue, then
// hands the synchronised switch value to writeback for one cycle.
module io_input_ctrl
  import io_input_ctrl_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          SIGN_EXT        = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switch_in,
  input  logic                button_in,
  input  logic                read_req,
  output logic                stall,
  output logic                data_valid,
  output logic [DATA_W-1:0]   data_out,
  output logic                press_pulse,
  output logic                waiting
);

  state_e              state;
  state_e              state_next;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [SW_WIDTH-1:0] data_reg;
  logic                btn_stable;
  logic                capture;

  io_input_ctrl_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock      (clock),
    .reset      (reset),
    .button_in  (button_in),
    .btn_stable (btn_stable),
    .press_pulse(press_pulse)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A held button must be released first so one press serves one request
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (read_req) begin
          state_next = btn_stable ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!read_req) begin
          state_next = ST_IDLE;
        end else if (!btn_stable) begin
          state_next = ST_WAIT_PRESS;
        end
      end
      ST_WAIT_PRESS: begin
        if (!read_req) begin
          state_next = ST_IDLE;
        end else if (press_pulse) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    waiting    = 1'b0;
    data_valid = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = read_req;
      end
      ST_WAIT_RELEASE: begin
        stall   = 1'b1;
        waiting = 1'b1;
      end
      ST_WAIT_PRESS: begin
        stall   = 1'b1;
        waiting = 1'b1;
        capture = read_req & press_pulse;
      end
      ST_DONE: begin
        data_valid = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
    end else if (capture) begin
      data_reg <= sw_sync;
    end
  end

  generate
    if (SIGN_EXT) begin : g_sext
      assign data_out = {{(DATA_W - SW_WIDTH){data_reg[SW_WIDTH-1]}}, data_reg};
    end else begin : g_zext
      assign data_out = {{(DATA_W - SW_WIDTH){1'b0}}, data_reg};
    end
  endgenerate

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios plus random button/switch/request
// traffic, all checked every cycle against a behavioural model.
module tb_io_input_ctrl;

  localparam int unsigned SW = 8;
  localparam int unsigned DB = 4;
  localparam bit          SX = 1'b1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] switch_in = '0;
  logic          button_in = 1'b0;
  logic          read_req = 1'b0;
  logic          stall, data_valid, press_pulse, waiting;
  logic [31:0]   data_out;

  int          n_checks = 0;
  int          n_fail = 0;
  int          dv_count = 0;
  int          pulse_count = 0;
  logic [31:0] last_data = '0;

  always #5 clock = ~clock;

  io_input_ctrl #(
    .SW_WIDTH(SW),
    .DEBOUNCE_CYCLES(DB),
    .SIGN_EXT(SX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .switch_in  (switch_in),
    .button_in  (button_in),
    .read_req   (read_req),
    .stall      (stall),
    .data_valid (data_valid),
    .data_out   (data_out),
    .press_pulse(press_pulse),
    .waiting    (waiting)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [SW-1:0] v);
    if (SX) return {{(32 - SW){v[SW-1]}}, v};
    return {{(32 - SW){1'b0}}, v};
  endfunction

  // Behavioural model: delayed samples, "last DB sync samples all disagree"
  // acceptance rule, and a request/serve bookkeeping of busy/release/deliver.
  logic          m_sh1 = 0, m_sh2 = 0;
  logic [SW-1:0] m_sw1 = '0, m_sw2 = '0;
  logic [DB-1:0] m_diff = '0;
  logic          m_stable = 0, m_stable_d = 0, m_pulse = 0;
  logic          m_busy = 0, m_need_rel = 0, m_deliver = 0;
  logic [SW-1:0] m_data = '0;

  always @(posedge clock) begin : model_and_compare
    logic          sync_now;
    logic [DB-1:0] diff_new;
    logic          stable_new, pulse_new, busy_n, need_n, deliver_n;
    logic [SW-1:0] data_n;
    if (reset) begin
      m_sh1 = 0; m_sh2 = 0; m_sw1 = '0; m_sw2 = '0; m_diff = '0;
      m_stable = 0; m_stable_d = 0; m_pulse = 0;
      m_busy = 0; m_need_rel = 0; m_deliver = 0; m_data = '0;
    end else begin
      sync_now   = m_sh2;
      diff_new   = {m_diff[DB-2:0], sync_now != m_stable};
      stable_new = m_stable;
      if (&diff_new) begin
        stable_new = ~m_stable;
        diff_new   = '0;
      end
      pulse_new = m_stable & ~m_stable_d;
      busy_n    = m_busy;
      need_n    = m_need_rel;
      deliver_n = 1'b0;
      data_n    = m_data;
      if (!m_deliver) begin
        if (!m_busy) begin
          if (read_req) begin
            busy_n = 1'b1;
            need_n = m_stable;
          end
        end else if (!read_req) begin
          busy_n = 1'b0;
        end else if (m_need_rel) begin
          if (!m_stable) need_n = 1'b0;
        end else if (m_pulse) begin
          data_n    = m_sw2;
          busy_n    = 1'b0;
          deliver_n = 1'b1;
        end
      end
      m_sh2 = m_sh1; m_sh1 = button_in;
      m_sw2 = m_sw1; m_sw1 = switch_in;
      m_diff = diff_new;
      m_stable_d = m_stable; m_stable = stable_new; m_pulse = pulse_new;
      m_busy = busy_n; m_need_rel = need_n; m_deliver = deliver_n; m_data = data_n;
    end
    #1;
    check("stall",       32'(stall),       32'(m_busy | (~m_deliver & read_req)));
    check("data_valid",  32'(data_valid),  32'(m_deliver));
    check("waiting",     32'(waiting),     32'(m_busy));
    check("press_pulse", 32'(press_pulse), 32'(m_pulse));
    check("data_out",    data_out,         ext(m_data));
    if (data_valid) begin
      dv_count++;
      last_data = data_out;
    end
    if (press_pulse) pulse_count++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_dv(input int max_cycles, output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!data_valid && n < max_cycles);
    if (!data_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL dv_timeout: no data_valid within %0d cycles", max_cycles);
    end
  endtask

  initial begin : stimulus
    int n;
    int dv0;
    int pl0;
    int run;
    int lv[7];
    int len[7];

    // reset state
    tick(3);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_data", data_out, 32'h0);
    check("rst_wait", 32'(waiting), 32'h0);
    check("rst_pulse", 32'(press_pulse), 32'h0);
    reset = 1'b0;
    tick(3);

    // request then clean press
    switch_in = 8'hA5;
    read_req  = 1'b1;
    #1 check("t1_stall_same_cycle", 32'(stall), 32'h1);
    tick(1);
    button_in = 1'b1;
    wait_dv(20, n);
    check("t1_latency", 32'(n), 32'd8);
    check("t1_data", data_out, 32'hFFFFFFA5);
    check("t1_stall_done", 32'(stall), 32'h0);
    tick(1);
    read_req = 1'b0;
    tick(12);
    button_in = 1'b0;
    tick(10);

    // bounce: glitches must not capture
    dv0 = dv_count;
    pl0 = pulse_count;
    switch_in = 8'h3C;
    read_req  = 1'b1;
    lv  = '{1, 0, 1, 0, 1, 0, 1};
    len = '{3, 3, 1, 1, 1, 3, 14};
    for (int i = 0; i < 7; i++) begin
      button_in = lv[i][0];
      tick(len[i]);
    end
    read_req  = 1'b0;
    button_in = 1'b0;
    tick(10);
    check("t2_dv_count", 32'(dv_count - dv0), 32'd1);
    check("t2_pulse_count", 32'(pulse_count - pl0), 32'd1);
    check("t2_data", last_data, 32'h0000003C);

    // held button before request
    dv0 = dv_count;
    button_in = 1'b1;
    tick(10);
    switch_in = 8'h5A;
    read_req  = 1'b1;
    tick(3);
    check("t3_waiting", 32'(waiting), 32'h1);
    tick(10);
    check("t3_no_dv_held", 32'(dv_count - dv0), 32'd0);
    button_in = 1'b0;
    tick(8);
    switch_in = 8'h96;
    tick(3);
    button_in = 1'b1;
    wait_dv(20, n);
    check("t3_latency", 32'(n), 32'd8);
    check("t3_data", data_out, 32'hFFFFFF96);
    tick(1);
    read_req = 1'b0;
    tick(12);
    button_in = 1'b0;
    tick(10);

    // back-to-back ecalls with read_req held high
    dv0 = dv_count;
    switch_in = 8'h01;
    read_req  = 1'b1;
    tick(1);
    button_in = 1'b1;
    wait_dv(20, n);
    check("t4_data1", data_out, 32'h00000001);
    tick(10);
    check("t4_wait_release", 32'(waiting), 32'h1);
    check("t4_single_dv", 32'(dv_count - dv0), 32'd1);
    button_in = 1'b0;
    tick(8);
    switch_in = 8'h7F;
    tick(3);
    button_in = 1'b1;
    wait_dv(20, n);
    check("t4_data2", data_out, 32'h0000007F);
    tick(1);
    read_req = 1'b0;
    tick(12);
    button_in = 1'b0;
    tick(10);

    // abort while waiting for a press
    switch_in = 8'h22;
    read_req  = 1'b1;
    tick(3);
    check("t5_waiting", 32'(waiting), 32'h1);
    read_req = 1'b0;
    @(posedge clock);
    #1;
    check("t5_abort_wait", 32'(waiting), 32'h0);
    check("t5_abort_stall", 32'(stall), 32'h0);
    check("t5_abort_dv", 32'(data_valid), 32'h0);
    check("t5_data_kept", data_out, 32'h0000007F);
    tick(3);

    // reset in the middle of a wait
    read_req = 1'b1;
    tick(3);
    reset = 1'b1;
    #1;
    check("t6_wait", 32'(waiting), 32'h0);
    check("t6_data", data_out, 32'h0);
    check("t6_pulse", 32'(press_pulse), 32'h0);
    check("t6_dv", 32'(data_valid), 32'h0);
    check("t6_stall", 32'(stall), 32'h1);
    read_req = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

    // random traffic
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) switch_in = SW'($urandom);
      if (run == 0) begin
        button_in = ~button_in;
        run = int'($urandom_range(1, 12));
      end else begin
        run--;
      end
      if (!read_req) begin
        if ($urandom_range(0, 15) == 0) read_req = 1'b1;
      end else if (data_valid) begin
        if ($urandom_range(0, 3) != 0) read_req = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        read_req = 1'b0;
      end
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
